// File: rtl/uart_cmd_pkg.sv
// Shared types, constants and checksum helper for the UART command parser.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CHK,
        OUT
    } parser_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT  = 8'hAA;
    localparam int         DATA_BYTES_DEFAULT = 2;
    localparam int         FRAME_LEN          = DATA_BYTES_DEFAULT + 3;

    function automatic int frame_len(input int data_bytes);
        return data_bytes + 3;
    endfunction

    // XOR of the address and the low data_bytes bytes of a right-aligned payload.
    function automatic logic [7:0] xor_checksum(
        input logic [7:0]  addr,
        input logic [31:0] payload,
        input int          data_bytes
    );
        logic [7:0] c;
        c = addr;
        for (int i = 0; i < 4; i++) begin
            if (i < data_bytes) c = c ^ payload[i*8 +: 8];
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: counts while enabled, clears on demand and
// raises expire for one cycle on reaching TIMEOUT_CYCLES-1 without a clear.
module uart_cmd_timer #(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // A clear in the limit cycle means a byte arrived in time, so it wins.
    assign expire = enable && !clear && (count_q == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clear || expire) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame parser between uart_rx and sensor logic: SYNC, ADDR, DATA (MSB first), CHK.
// Inter-byte timeout is built only when UART_CMD_PARSER_TIMEOUT_EN is defined.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         DATA_WIDTH     = 8,
    parameter int         DATA_BYTES     = 2,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   cmd_addr,
    output logic [8*DATA_BYTES-1:0] cmd_data,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic                    chk_err,
    output logic                    timeout_err,
    output logic [7:0]              err_cnt,
    output parser_state_e           dbg_state
);

    // Handshakes: a transfer happens on a clk edge where valid && ready are
    // both high; the source holds its payload stable until that edge.

    localparam logic [1:0] IDX_LAST = 2'(DATA_BYTES - 1);

    parser_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [8*DATA_BYTES-1:0] data_q, data_d;
    logic [7:0]              chk_q, chk_d;
    logic [1:0]              idx_q, idx_d;
    logic                    chk_err_q, chk_err_d;
    logic [7:0]              err_cnt_q;
    logic                    accept;
    logic                    expire;
    logic                    err_event;

    assign in_ready  = (state_q != OUT);
    assign accept    = in_valid && in_ready;
    assign cmd_valid = (state_q == OUT);
    assign cmd_addr  = addr_q;
    assign cmd_data  = data_q;
    assign chk_err   = chk_err_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;
    logic timeout_q;

    assign timer_clear  = accept || (state_q == IDLE) || (state_q == OUT);
    assign timer_enable = (state_q == ADDR) || (state_q == DATA) || (state_q == CHK);

    uart_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= expire;
    end

    assign timeout_err = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        chk_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_d = ADDR;
            end
            ADDR: begin
                // SYNC_BYTE is ordinary data here; resync only happens from IDLE.
                if (accept) begin
                    addr_d  = in_data;
                    chk_d   = in_data;
                    idx_d   = IDX_LAST;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    data_d[idx_q*8 +: 8] = in_data;
                    chk_d                = chk_q ^ in_data;
                    if (idx_q == 2'd0) state_d = CHK;
                    else               idx_d   = idx_q - 2'd1;
                end
            end
            CHK: begin
                if (accept) begin
                    if (in_data == chk_q) begin
                        state_d = OUT;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            OUT: begin
                if (cmd_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // expire is only raised in a cycle with no accepted byte.
        if (expire) state_d = IDLE;
    end

    assign err_event = chk_err_d || expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            chk_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            chk_err_q <= chk_err_d;
            if (err_event && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: byte driver plus a scoreboard monitor
// that checks commands and error pulses against expected queues.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int DB = 2;
    localparam int W  = 8 + 8*DB;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    cmd_addr;
    logic [8*DB-1:0] cmd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          chk_err;
    logic          timeout_err;
    logic [7:0]    err_cnt;
    parser_state_e dbg_state;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_err_q[$];
    logic [7:0]   exp_err_cnt;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .DATA_WIDTH     (8),
        .DATA_BYTES     (DB),
        .SYNC_BYTE      (8'hAA),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .chk_err     (chk_err),
        .timeout_err (timeout_err),
        .err_cnt     (err_cnt),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_err(input logic [1:0] code);
        exp_err_q.push_back(code);
        if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL in_ready_wait: in_ready still %b after %0d cycles, required 1", in_ready, waited);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pop and compare whenever the DUT presents a command or an error pulse.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL cmd_unexpected: got %h, no command expected", {cmd_addr, cmd_data});
                end else begin
                    check("cmd", 32'({cmd_addr, cmd_data}), 32'(exp_q.pop_front()));
                end
            end
            if (chk_err) begin
                if (exp_err_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL chk_err_unexpected: got pulse, none expected");
                end else begin
                    check("err_kind_chk", 32'd1, 32'(exp_err_q.pop_front()));
                end
            end
            if (timeout_err) begin
                if (exp_err_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL timeout_err_unexpected: got pulse, none expected");
                end else begin
                    check("err_kind_timeout", 32'd2, 32'(exp_err_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        cmd_ready   = 1'b1;
        exp_err_cnt = 8'h00;
        idle(3);
        rst = 1'b0;

        // reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        check("rst_cmd_data", 32'(cmd_data), 32'd0);
        check("rst_chk_err", 32'(chk_err), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // good frame, command visible one cycle after CHK handshake
        exp_q.push_back(24'h10_1234);
        send_frame(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
        check("good_latency", 32'(cmd_valid), 32'd1);
        idle(3);
        check("good_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
        check("good_drained", 32'(exp_q.size()), 32'd0);

        // leading garbage is dropped silently
        exp_q.push_back(24'h10_1234);
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
        idle(3);
        check("garbage_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
        check("garbage_drained", 32'(exp_q.size()), 32'd0);

        // bad checksum, then a good frame
        expect_err(2'd1);
        send_frame(8'hAA, 8'h10, 8'h12, 8'h34, 8'h37);
        idle(2);
        check("badchk_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
        check("badchk_state", 32'(dbg_state), 32'(IDLE));
        exp_q.push_back(24'h20_0001);
        send_frame(8'hAA, 8'h20, 8'h00, 8'h01, 8'h21);
        idle(3);
        check("after_badchk_drained", 32'(exp_q.size()), 32'd0);

        // backpressure: command held while upstream offers a SYNC byte
        cmd_ready = 1'b0;
        exp_q.push_back(24'h10_1234);
        send_frame(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
        @(negedge clk);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_cmd_valid", 32'(cmd_valid), 32'd1);
            check("bp_cmd_hold", 32'({cmd_addr, cmd_data}), 32'h0010_1234);
            @(negedge clk);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_sync_taken", 32'(dbg_state), 32'(ADDR));
        exp_q.push_back(24'h20_0001);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h21);
        idle(3);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // stalled frame
`ifdef UART_CMD_PARSER_TIMEOUT_EN
        expect_err(2'd2);
        send_byte(8'hAA);
        send_byte(8'h10);
        idle(60);
        check("timeout_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
        check("timeout_state", 32'(dbg_state), 32'(IDLE));
        exp_q.push_back(24'h10_1234);
        send_frame(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
        idle(3);
`else
        send_byte(8'hAA);
        send_byte(8'h10);
        idle(60);
        check("stall_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
        check("stall_state", 32'(dbg_state), 32'(DATA));
        exp_q.push_back(24'h10_1234);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h36);
        idle(3);
`endif
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // reset mid-frame
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'h12);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err_cnt = 8'h00;
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_addr", 32'(cmd_addr), 32'd0);
        check("midrst_data", 32'(cmd_data), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(24'h10_1234);
        send_frame(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
        idle(3);
        check("midrst_drained", 32'(exp_q.size()), 32'd0);

        // error counter saturation
        for (int i = 0; i < 260; i++) begin
            expect_err(2'd1);
            send_frame(8'hAA, 8'h10, 8'h12, 8'h34, 8'h37);
        end
        idle(3);
        check("sat_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
        check("sat_err_drained", 32'(exp_err_q.size()), 32'd0);
        check("final_cmd_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of uart_rx and consumes its byte stream through a valid/ready handshake.
- Assembles fixed-length command frames from the PC, checks them and presents one (address, data) command to the sensor-side logic.
- Frame layout: SYNC, ADDR, DATA[DATA_BYTES-1] … DATA[0] (MSB first), CHK. CHK = XOR of ADDR and all data bytes.
- Drops malformed or stalled frames and counts errors.

Parameters:
- DATA_WIDTH, 8, byte width of the input stream (fixed at 8 for this block).
- DATA_BYTES, 2, number of payload bytes per frame (1..4).
- SYNC_BYTE, 8'hAA, frame start marker.
- TIMEOUT_CYCLES, 100_000, maximum clk cycles allowed between accepted bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  8  byte from uart_rx.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  parser can accept a byte.
- cmd_addr  out  8  command address.
- cmd_data  out  8*DATA_BYTES  command payload, first received byte in the MSBs.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  consumer accepts the command.
- chk_err  out  1  one-cycle pulse on checksum mismatch.
- timeout_err  out  1  one-cycle pulse on inter-byte timeout.
- err_cnt  out  8  saturating error count.

Behaviour:
- Reset: state=IDLE, in_ready=1, cmd_valid=0, cmd_addr=0, cmd_data=0, chk_err=0, timeout_err=0, err_cnt=0, timeout counter=0.
  - rst asserted mid-frame or while holding a command discards everything, with no error pulse.
- A byte is accepted when in_valid && in_ready are both high at a clk edge.
- in_ready=1 in every state except OUT.
- State machine:
  - IDLE: accepted byte == SYNC_BYTE → ADDR. Any other byte is silently dropped (no error).
  - ADDR: accepted byte → cmd_addr register; running checksum := byte; byte index := DATA_BYTES-1; → DATA. A byte equal to SYNC_BYTE is treated as data here (no resync).
  - DATA: accepted byte → payload slot [index]; checksum ^= byte. At index 0 → CHK, otherwise index--.
  - CHK, byte == checksum: → OUT, with cmd_valid=1 in the cycle after the CHK handshake (1-cycle latency).
  - CHK, byte != checksum: chk_err pulses for 1 cycle, err_cnt++, → IDLE, no command issued.
  - OUT: cmd_valid, cmd_addr and cmd_data are held stable until cmd_valid && cmd_ready. On that handshake cmd_valid=0 and → IDLE in the next cycle. in_ready=0 here, so upstream uart_rx buffers or overwrites per its own rules.
- Timeout counter:
  - Clears on every accepted byte and whenever the state is IDLE or OUT.
  - Increments in ADDR, DATA and CHK.
  - On reaching TIMEOUT_CYCLES-1 with no byte accepted: timeout_err pulses, err_cnt++, → IDLE, partial frame discarded.
  - A byte accepted in the same cycle the limit is reached takes priority; no timeout occurs.
- err_cnt saturates at 8'hFF and never wraps. If chk_err and timeout_err would fire in the same cycle, only chk_err fires; they are mutually exclusive by the byte-priority rule.
- Counter width is $clog2(TIMEOUT_CYCLES).

Optional Feature:
- Macro: UART_CMD_PARSER_TIMEOUT_EN.
- Defined: timeout counter, timeout_err and the timeout transition are present as described above.
- Undefined: no counter logic is generated, timeout_err is tied to 0, and a stalled frame waits indefinitely for its next byte.

Decomposition:
- Package uart_cmd_pkg holds:
  - parser state enum (IDLE, ADDR, DATA, CHK, OUT);
  - default SYNC_BYTE constant;
  - function for the XOR checksum over an address and a payload vector;
  - frame length constant (DATA_BYTES+3).
- One natural sub-module: uart_cmd_timer, the inter-byte timeout counter with clear/enable/expire. Instantiated only under UART_CMD_PARSER_TIMEOUT_EN.

Test Plan:
- Good frame: bytes AA 10 12 34 36, cmd_ready=1 → cmd_valid for 1 cycle, cmd_addr=8'h10, cmd_data=16'h1234, err_cnt=0.
- Leading garbage: 55 00 FF, then AA 10 12 34 36 → one command only (addr 10, data 1234), no error pulses, err_cnt=0.
- Bad checksum: AA 10 12 34 37 → chk_err pulses once, no cmd_valid, err_cnt=1. A following good frame AA 20 00 01 21 → addr 20, data 0001.
- Backpressure: good frame with cmd_ready=0 for 20 cycles while in_valid=1 with byte AA → in_ready=0 and outputs stable throughout. After cmd_ready=1: handshake, then in_ready=1 and AA is accepted as the start of a new frame.
- Timeout (macro defined, TIMEOUT_CYCLES=50): send AA 10, then idle 60 cycles → timeout_err pulses once, err_cnt=1. The next full frame AA 10 12 34 36 parses correctly. With the macro undefined the same stimulus gives no pulse, and trailing bytes 12 34 36 complete the frame.
- Reset mid-frame and saturation:
  - rst for 1 cycle after AA 10 12 → IDLE, outputs zeroed; next good frame parses correctly.
  - 260 bad-checksum frames → err_cnt=8'hFF, no wrap.
